fb_port_arbiter: RTL and testbench

- Shares one single-port synchronous frame-buffer RAM (160x120, 12-bit RGB444) between two requesters: the VGA display read path and the camera capture write path.
- The VGA read path has absolute priority, so display pixels are never late.
- Camera writes are queued in an internal FIFO and drained into the RAM on cycles with no read.
- Sits between the capture block, the VGA pixel-fetch logic and the frame-buffer RAM, all in the 25 MHz pixel clock domain.

---
 rtl/fb_port_arbiter.sv | 125 ++++++++++++
 tb/tb_fb_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one single-port frame-buffer RAM between the VGA
// read path (absolute priority) and the camera write path (queued in a small
// FIFO and drained on cycles with no read). Single clock domain.
module fb_port_arbiter #(
    parameter int AW         = 15,
    parameter int DW         = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int CW         = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    // VGA read path
    input  logic                          rd_req,
    input  logic [AW-1:0]                 rd_addr,
    output logic [DW-1:0]                 rd_data,
    output logic                          rd_valid,
    // camera write path
    input  logic                          wr_valid,
    input  logic [AW-1:0]                 wr_addr,
    input  logic [DW-1:0]                 wr_data,
    output logic                          wr_ready,
    // frame-buffer RAM port
    output logic [AW-1:0]                 mem_addr,
    output logic                          mem_we,
    output logic [DW-1:0]                 mem_wdata,
    input  logic [DW-1:0]                 mem_rdata,
    // status
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ovf,
    output logic [CW-1:0]                 drop_cnt,
    input  logic                          clr_ovf
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] DEPTH = LW'(FIFO_DEPTH);

    // Write-queue storage and pointers; pointers wrap naturally at FIFO_DEPTH.
    logic [AW-1:0] qAddr [FIFO_DEPTH];
    logic [DW-1:0] qData [FIFO_DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;

    logic fifoEmpty;
    logic fifoFull;
    logic push;
    logic pop;
    logic drop;

    assign fifoEmpty = (fifo_level == '0);
    assign fifoFull  = (fifo_level == DEPTH);

    // No push-through when full, even if the head drains this cycle.
    assign wr_ready  = rst & ~fifoFull;
    assign push      = wr_valid & wr_ready;
    // The head drains only on cycles the display does not need the RAM.
    assign pop       = rst & ~rd_req & ~fifoEmpty;
    assign drop      = rst & wr_valid & fifoFull;

    // Read data comes straight from the RAM; rd_valid marks the cycle it is good.
    assign rd_data   = mem_rdata;

    // Fixed-priority grant of the RAM port: read, else drain, else idle.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (rd_req) begin
            mem_addr = rd_addr;
        end else if (pop) begin
            mem_addr  = qAddr[rdPtr];
            mem_wdata = qData[rdPtr];
            mem_we    = 1'b1;
        end
    end

    // Queue storage: capture the accepted write at the tail slot.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the pointers and level define what is valid.
        if (push) begin
            qAddr[wrPtr] <= wr_addr;
            qData[wrPtr] <= wr_data;
        end
    end

    // Queue pointers and occupancy; push and pop together leave the level unchanged.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop)  rdPtr <= rdPtr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Read-valid follows an accepted read by exactly one cycle.
    always_ff @(posedge clk) begin
        if (!rst) rd_valid <= 1'b0;
        else      rd_valid <= rd_req;
    end

    // Drop accounting: sticky flag plus saturating counter; clear wins over a drop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (clr_ovf) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed bench for fb_port_arbiter with a behavioural
// frame-buffer RAM and scoreboards for read data and RAM write order.
module tb_fb_port_arbiter;

    localparam int AW         = 15;
    localparam int DW         = 12;
    localparam int FIFO_DEPTH = 8;
    localparam int CW         = 4;   // narrow so saturation is reachable quickly
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;
    localparam int RAM_WORDS  = 2 ** AW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_ent_t;

    logic          clk;
    logic          rst;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [LW-1:0] fifo_level;
    logic          ovf;
    logic [CW-1:0] drop_cnt;
    logic          clr_ovf;

    logic          preload;
    logic          expRdValid;
    logic [DW-1:0] ram [RAM_WORDS];

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] rdQ [$];
    wr_ent_t       wrQ [$];

    fb_port_arbiter #(
        .AW(AW), .DW(DW), .FIFO_DEPTH(FIFO_DEPTH), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .fifo_level(fifo_level), .ovf(ovf), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM, read-before-write, 1-cycle read latency.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < RAM_WORDS; i++) ram[i] <= '0;
            ram[5] <= 12'hABC;
            ram[6] <= 12'h123;
        end else if (mem_we === 1'b1) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    // Reference for the read-valid register.
    always @(posedge clk) expRdValid <= (rst === 1'b1) && (rd_req === 1'b1);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: compare DUT outputs mid-cycle.
    always @(negedge clk) begin
        check("rd_valid", {31'b0, rd_valid}, {31'b0, expRdValid});
        if (rd_valid === 1'b1) begin
            check("rd_q_has_entry", {31'b0, rdQ.size() != 0}, 32'd1);
            if (rdQ.size() != 0) begin
                logic [DW-1:0] e;
                e = rdQ.pop_front();
                check("rd_data", 32'(rd_data), 32'(e));
            end
        end
        if (rd_req === 1'b1 || rst === 1'b0)
            check("mem_we_blocked", {31'b0, mem_we}, 32'd0);
        if (mem_we === 1'b1) begin
            check("wr_q_has_entry", {31'b0, wrQ.size() != 0}, 32'd1);
            if (wrQ.size() != 0) begin
                wr_ent_t w;
                w = wrQ.pop_front();
                check("mem_addr_order", 32'(mem_addr), 32'(w.addr));
                check("mem_wdata_order", 32'(mem_wdata), 32'(w.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs and record what the bench expects from them.
    task automatic drive(input logic r, input logic [AW-1:0] ra, input logic [DW-1:0] rexp,
                         input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic wacc);
        wr_ent_t ent;
        rd_req   = r;
        rd_addr  = ra;
        wr_valid = w;
        wr_addr  = wa;
        wr_data  = wd;
        if (r && rst) rdQ.push_back(rexp);
        if (w && wacc) begin
            ent.addr = wa;
            ent.data = wd;
            wrQ.push_back(ent);
        end
        #1;
        if (w) check("wr_ready", {31'b0, wr_ready}, {31'b0, wacc});
    endtask

    initial begin
        rst      = 1'b0;
        rd_req   = 1'b1;
        rd_addr  = '0;
        wr_valid = 1'b1;
        wr_addr  = 15'd7;
        wr_data  = 12'hFFF;
        clr_ovf  = 1'b0;
        preload  = 1'b1;

        // Reset held three cycles with both requesters active.
        for (int i = 0; i < 3; i++) begin
            tick();
            preload = 1'b0;
            check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
            check("rst_mem_we", {31'b0, mem_we}, 32'd0);
            check("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
            check("rst_level", 32'(fifo_level), 32'd0);
            check("rst_ovf", {31'b0, ovf}, 32'd0);
        end
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        check("release_wr_ready", {31'b0, wr_ready}, 32'd1);
        check("release_drop_cnt", 32'(drop_cnt), 32'd0);
        tick();

        // Back-to-back reads of preloaded words.
        drive(1'b1, 15'd5, 12'hABC, 1'b0, '0, '0, 1'b0);
        check("rd_grant_addr", 32'(mem_addr), 32'd5);
        tick();
        drive(1'b1, 15'd6, 12'h123, 1'b0, '0, '0, 1'b0);
        check("rd_grant_addr2", 32'(mem_addr), 32'd6);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        tick();

        // Writes queue behind continuous reads; reads of addr 10 see RAM, not the queue.
        drive(1'b1, 15'd10, 12'h000, 1'b1, 15'd10, 12'h111, 1'b1);
        tick();
        drive(1'b1, 15'd10, 12'h000, 1'b1, 15'd11, 12'h222, 1'b1);
        tick();
        drive(1'b1, 15'd10, 12'h000, 1'b1, 15'd12, 12'h333, 1'b1);
        tick();
        drive(1'b1, 15'd10, 12'h000, 1'b0, '0, '0, 1'b0);
        check("queued_level", 32'(fifo_level), 32'd3);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
            check("drain_we", {31'b0, mem_we}, 32'd1);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        check("drained_level", 32'(fifo_level), 32'd0);
        check("idle_we", {31'b0, mem_we}, 32'd0);
        drive(1'b1, 15'd10, 12'h111, 1'b0, '0, '0, 1'b0);
        tick();
        drive(1'b1, 15'd11, 12'h222, 1'b0, '0, '0, 1'b0);
        tick();
        drive(1'b1, 15'd12, 12'h333, 1'b0, '0, '0, 1'b0);
        tick();

        // Fill past capacity under continuous reads: 8 accepted, 2 dropped.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, '0, 12'h000, 1'b1, AW'(20 + i), DW'(12'h400 + i), i < FIFO_DEPTH);
            tick();
        end
        drive(1'b1, '0, 12'h000, 1'b0, '0, '0, 1'b0);
        check("full_level", 32'(fifo_level), 32'd8);
        check("full_ovf", {31'b0, ovf}, 32'd1);
        check("full_drop_cnt", 32'(drop_cnt), 32'd2);
        tick();
        // 15 more drops: 17 total saturates a 4-bit counter at 15.
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, '0, 12'h000, 1'b1, 15'd30, 12'h7FF, 1'b0);
            tick();
        end
        check("sat_drop_cnt", 32'(drop_cnt), 32'd15);
        // Clear coincides with another drop; the clear wins.
        clr_ovf = 1'b1;
        drive(1'b1, '0, 12'h000, 1'b1, 15'd31, 12'h7FE, 1'b0);
        tick();
        clr_ovf = 1'b0;
        drive(1'b1, '0, 12'h000, 1'b0, '0, '0, 1'b0);
        check("clr_ovf", {31'b0, ovf}, 32'd0);
        check("clr_drop_cnt", 32'(drop_cnt), 32'd0);
        check("clr_level", 32'(fifo_level), 32'd8);
        tick();

        // Drain four, then push and pop together five times across pointer wrap.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
            tick();
        end
        check("half_level", 32'(fifo_level), 32'd4);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, '0, '0, 1'b1, AW'(40 + i), DW'(12'h500 + i), 1'b1);
            check("pushpop_we", {31'b0, mem_we}, 32'd1);
            tick();
            check("pushpop_level", 32'(fifo_level), 32'd4);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
            tick();
        end
        check("pushpop_empty", 32'(fifo_level), 32'd0);
        check("pushpop_no_drop", 32'(drop_cnt), 32'd0);

        // Reset in the middle of a drain discards everything queued.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, '0, 12'h000, 1'b1, AW'(50 + i), DW'(12'h600 + i), 1'b1);
            tick();
        end
        drive(1'b0, '0, '0, 1'b1, 15'd55, 12'h605, 1'b1);
        check("middrain_we", {31'b0, mem_we}, 32'd1);
        tick();
        check("middrain_level", 32'(fifo_level), 32'd5);
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        check("midrst_we", {31'b0, mem_we}, 32'd0);
        check("midrst_wr_ready", {31'b0, wr_ready}, 32'd0);
        wrQ.delete();
        tick();
        check("midrst_level", 32'(fifo_level), 32'd0);
        check("midrst_rd_valid", {31'b0, rd_valid}, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
            check("post_rst_no_we", {31'b0, mem_we}, 32'd0);
            tick();
        end

        // Everything expected must have been produced.
        tick();
        check("rd_q_drained", 32'(rdQ.size()), 32'd0);
        check("wr_q_drained", 32'(wrQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
